// File: rtl/viterbi_traceback.sv
// Survivor-path traceback for an 8-state (K=4) Viterbi decoder: stores BLOCK
// survivor vectors, traces back from the best final state, then emits bits in time order.
module viterbi_traceback #(
  parameter int BLOCK  = 8,
  parameter int NSTATE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sv_valid,
  output logic              sv_ready,
  input  logic [NSTATE-1:0] sv_bits,
  input  logic [2:0]        sv_best,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic              dec_bit,
  output logic              dec_last
);

  localparam int AW = $clog2(BLOCK);
  localparam logic [AW-1:0] LAST = AW'(BLOCK - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_TRACE = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [2:0]        cur_state_q, cur_state_d;
  logic              sv_ready_q, sv_ready_d;
  logic              dec_valid_q, dec_valid_d;
  logic              dec_bit_q, dec_bit_d;
  logic              dec_last_q, dec_last_d;

  logic [NSTATE-1:0] mem_q [BLOCK];
  logic [BLOCK-1:0]  out_buf_q;
  logic              mem_we_s;
  logic              buf_we_s;
  logic              sel_s;
  logic [AW-1:0]     rd_nxt_s;

  assign sel_s    = mem_q[idx_q][cur_state_q];
  assign rd_nxt_s = rd_cnt_q + ONE;

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    idx_d       = idx_q;
    rd_cnt_d    = rd_cnt_q;
    cur_state_d = cur_state_q;
    dec_valid_d = dec_valid_q;
    dec_bit_d   = dec_bit_q;
    dec_last_d  = dec_last_q;
    mem_we_s    = 1'b0;
    buf_we_s    = 1'b0;
    case (state_q)
      S_FILL: begin
        if (sv_valid && sv_ready_q) begin
          mem_we_s = 1'b1;
          if (wr_cnt_q == LAST) begin
            cur_state_d = sv_best;
            idx_d       = LAST;
            wr_cnt_d    = '0;
            state_d     = S_TRACE;
          end else begin
            wr_cnt_d = wr_cnt_q + ONE;
          end
        end else begin
          wr_cnt_d = wr_cnt_q;
        end
      end
      S_TRACE: begin
        // Predecessor of s under selection b is {b, s[2:1]}; decoded bit is s[0].
        buf_we_s    = 1'b1;
        cur_state_d = {sel_s, cur_state_q[2:1]};
        if (idx_q == '0) begin
          rd_cnt_d = '0;
          state_d  = S_EMIT;
        end else begin
          idx_d = idx_q - ONE;
        end
      end
      S_EMIT: begin
        // First EMIT cycle loads the output register; later cycles advance on handshake.
        if (!dec_valid_q) begin
          dec_valid_d = 1'b1;
          dec_bit_d   = out_buf_q[rd_cnt_q];
          dec_last_d  = (rd_cnt_q == LAST);
        end else if (dec_ready) begin
          if (dec_last_q) begin
            dec_valid_d = 1'b0;
            dec_bit_d   = 1'b0;
            dec_last_d  = 1'b0;
            rd_cnt_d    = '0;
            state_d     = S_FILL;
          end else begin
            rd_cnt_d   = rd_nxt_s;
            dec_bit_d  = out_buf_q[rd_nxt_s];
            dec_last_d = (rd_nxt_s == LAST);
          end
        end else begin
          dec_valid_d = dec_valid_q;
        end
      end
      default: begin
        state_d     = S_FILL;
        dec_valid_d = 1'b0;
        dec_bit_d   = 1'b0;
        dec_last_d  = 1'b0;
      end
    endcase
    sv_ready_d = (state_d == S_FILL);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      wr_cnt_q    <= '0;
      idx_q       <= '0;
      rd_cnt_q    <= '0;
      cur_state_q <= 3'd0;
      sv_ready_q  <= 1'b1;
      dec_valid_q <= 1'b0;
      dec_bit_q   <= 1'b0;
      dec_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      idx_q       <= idx_d;
      rd_cnt_q    <= rd_cnt_d;
      cur_state_q <= cur_state_d;
      sv_ready_q  <= sv_ready_d;
      dec_valid_q <= dec_valid_d;
      dec_bit_q   <= dec_bit_d;
      dec_last_q  <= dec_last_d;
    end
  end

  // Survivor memory and traceback buffer carry no reset; contents are qualified by the FSM.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_cnt_q] <= sv_bits;
    end
    if (buf_we_s) begin
      out_buf_q[idx_q] <= cur_state_q[0];
    end
  end

  assign sv_ready  = sv_ready_q;
  assign dec_valid = dec_valid_q;
  assign dec_bit   = dec_bit_q;
  assign dec_last  = dec_last_q;

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed testbench for viterbi_traceback: reset, zero block, known path,
// backpressure, busy-input rejection and reset during traceback.
module tb_viterbi_traceback;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sv_valid = 1'b0;
  logic       sv_ready;
  logic [7:0] sv_bits = 8'h00;
  logic [2:0] sv_best = 3'd0;
  logic       dec_valid;
  logic       dec_ready = 1'b0;
  logic       dec_bit;
  logic       dec_last;

  int tests_run = 0;
  int tests_failed = 0;

  // Input 1,0,1,1,0,0,1,0 from state 0 visits 1,2,5,3,6,4,1,2; the selection bit at
  // step t, state s_{t+1}, is s_t[2] -> vectors 00,00,00,08,00,10,02,00 (step 7 in MSBs).
  localparam logic [63:0] KNOWN_VECS = 64'h0002_1000_0800_0000;
  localparam logic [2:0]  KNOWN_BEST = 3'b010;
  localparam logic [7:0]  KNOWN_EXP  = 8'h4D;   // bit i = i-th decoded bit
  localparam logic [7:0]  LAST_EXP   = 8'h80;

  viterbi_traceback #(.BLOCK(8), .NSTATE(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sv_valid  (sv_valid),
    .sv_ready  (sv_ready),
    .sv_bits   (sv_bits),
    .sv_best   (sv_best),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .dec_bit   (dec_bit),
    .dec_last  (dec_last)
  );

  always #5 clk = ~clk;

  task automatic send_block(input logic [63:0] vecs, input logic [2:0] best, input int nvec);
    for (int t = 0; t < nvec; t++) begin
      sv_valid = 1'b1;
      sv_bits  = vecs[8*t +: 8];
      sv_best  = (t == 7) ? best : 3'b111;
      @(posedge clk); #1;
    end
    sv_valid = 1'b0;
    sv_bits  = 8'h00;
  endtask

  task automatic collect(input bit toggle, output logic [7:0] bits, output logic [7:0] lasts,
                         output int n, output int stab_err, output int rdy_hi);
    logic pv, pr, pb, pl;
    bits = 8'h00; lasts = 8'h00; n = 0; stab_err = 0; rdy_hi = 0;
    pv = 1'b0; pr = 1'b1; pb = 1'b0; pl = 1'b0;
    for (int c = 0; c < 100; c++) begin
      dec_ready = toggle ? c[0] : 1'b1;
      if (pv && !pr && dec_valid && (dec_bit !== pb || dec_last !== pl)) stab_err++;
      if (sv_ready) rdy_hi++;
      pv = dec_valid; pr = dec_ready; pb = dec_bit; pl = dec_last;
      @(posedge clk); #1;
      if (pv && pr) begin
        if (n < 8) begin
          bits[n]  = pb;
          lasts[n] = pl;
        end
        n++;
        if (pl) break;
      end
    end
    dec_ready = 1'b0;
  endtask

  task automatic test_reset;
    int seen_valid;
    rst_n = 1'b0; #1;
    tests_run++; if (sv_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_sv_ready got %b exp 1", sv_ready); end
    tests_run++; if (dec_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_dec_valid got %b exp 0", dec_valid); end
    tests_run++; if (dec_last !== 1'b0) begin tests_failed++; $display("FAIL reset_dec_last got %b exp 0", dec_last); end
    tests_run++; if (dec_bit !== 1'b0) begin tests_failed++; $display("FAIL reset_dec_bit got %b exp 0", dec_bit); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send_block(KNOWN_VECS, KNOWN_BEST, 7);
    seen_valid = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (dec_valid) seen_valid++;
    end
    tests_run++; if (seen_valid !== 0) begin tests_failed++; $display("FAIL partial_no_output got %0d exp 0", seen_valid); end
    tests_run++; if (sv_ready !== 1'b1) begin tests_failed++; $display("FAIL partial_still_fill got %b exp 1", sv_ready); end
    // Discard the partial block.
    rst_n = 1'b0; #2;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_block;
    int lat, n, stab, rdy;
    logic [7:0] bits, lasts;
    send_block(64'h0, 3'd0, 8);
    lat = 1;
    while (!dec_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    tests_run++; if (lat !== 10) begin tests_failed++; $display("FAIL zero_latency got %0d exp 9", lat - 1); end
    collect(1'b0, bits, lasts, n, stab, rdy);
    tests_run++; if (n !== 8) begin tests_failed++; $display("FAIL zero_count got %0d exp 8", n); end
    tests_run++; if (bits !== 8'h00) begin tests_failed++; $display("FAIL zero_bits got %h exp 00", bits); end
    tests_run++; if (lasts !== LAST_EXP) begin tests_failed++; $display("FAIL zero_last got %h exp %h", lasts, LAST_EXP); end
    tests_run++; if (rdy !== 0) begin tests_failed++; $display("FAIL zero_busy_ready got %0d exp 0", rdy); end
    tests_run++; if (sv_ready !== 1'b1) begin tests_failed++; $display("FAIL zero_ready_after got %b exp 1", sv_ready); end
  endtask

  task automatic test_known_path;
    int n, stab, rdy;
    logic [7:0] bits, lasts;
    send_block(KNOWN_VECS, KNOWN_BEST, 8);
    collect(1'b0, bits, lasts, n, stab, rdy);
    tests_run++; if (n !== 8) begin tests_failed++; $display("FAIL known_count got %0d exp 8", n); end
    tests_run++; if (bits !== KNOWN_EXP) begin tests_failed++; $display("FAIL known_bits got %h exp %h", bits, KNOWN_EXP); end
    tests_run++; if (lasts !== LAST_EXP) begin tests_failed++; $display("FAIL known_last got %h exp %h", lasts, LAST_EXP); end
  endtask

  task automatic test_backpressure;
    int n, stab, rdy;
    logic [7:0] bits, lasts;
    send_block(KNOWN_VECS, KNOWN_BEST, 8);
    collect(1'b1, bits, lasts, n, stab, rdy);
    tests_run++; if (n !== 8) begin tests_failed++; $display("FAIL bp_count got %0d exp 8", n); end
    tests_run++; if (bits !== KNOWN_EXP) begin tests_failed++; $display("FAIL bp_bits got %h exp %h", bits, KNOWN_EXP); end
    tests_run++; if (lasts !== LAST_EXP) begin tests_failed++; $display("FAIL bp_last got %h exp %h", lasts, LAST_EXP); end
    tests_run++; if (stab !== 0) begin tests_failed++; $display("FAIL bp_stable got %0d changes exp 0", stab); end
    tests_run++; if (rdy !== 0) begin tests_failed++; $display("FAIL bp_busy_ready got %0d exp 0", rdy); end
    tests_run++; if (sv_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_after got %b exp 1", sv_ready); end
  endtask

  task automatic test_busy_ignored;
    int n, stab, rdy, busy_rdy;
    logic [7:0] bits, lasts;
    send_block(KNOWN_VECS, KNOWN_BEST, 8);
    sv_valid = 1'b1;
    sv_bits  = 8'hFF;
    sv_best  = 3'b111;
    busy_rdy = 0;
    for (int c = 0; c < 12; c++) begin
      if (sv_ready) busy_rdy++;
      @(posedge clk); #1;
    end
    sv_valid = 1'b0;
    sv_bits  = 8'h00;
    tests_run++; if (busy_rdy !== 0) begin tests_failed++; $display("FAIL busy_ready got %0d exp 0", busy_rdy); end
    collect(1'b0, bits, lasts, n, stab, rdy);
    tests_run++; if (bits !== KNOWN_EXP || n !== 8) begin tests_failed++; $display("FAIL busy_known_bits got %h/%0d exp %h/8", bits, n, KNOWN_EXP); end
    send_block(64'h0, 3'd0, 8);
    collect(1'b0, bits, lasts, n, stab, rdy);
    tests_run++; if (bits !== 8'h00 || n !== 8) begin tests_failed++; $display("FAIL busy_next_zero got %h/%0d exp 00/8", bits, n); end
    tests_run++; if (lasts !== LAST_EXP) begin tests_failed++; $display("FAIL busy_next_last got %h exp %h", lasts, LAST_EXP); end
  endtask

  task automatic test_reset_mid_trace;
    int n, stab, rdy;
    logic [7:0] bits, lasts;
    send_block(KNOWN_VECS, KNOWN_BEST, 8);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    tests_run++; if (sv_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_busy_before got %b exp 0", sv_ready); end
    #2 rst_n = 1'b0; #1;
    tests_run++; if (sv_ready !== 1'b1 || dec_valid !== 1'b0 || dec_bit !== 1'b0 || dec_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs got rdy=%b v=%b b=%b l=%b exp 1000", sv_ready, dec_valid, dec_bit, dec_last);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send_block(64'h0, 3'd0, 8);
    collect(1'b0, bits, lasts, n, stab, rdy);
    tests_run++; if (n !== 8) begin tests_failed++; $display("FAIL mid_count got %0d exp 8", n); end
    tests_run++; if (bits !== 8'h00) begin tests_failed++; $display("FAIL mid_bits got %h exp 00", bits); end
    tests_run++; if (lasts !== LAST_EXP) begin tests_failed++; $display("FAIL mid_last got %h exp %h", lasts, LAST_EXP); end
  endtask

  initial begin
    #1;
    test_reset;
    test_zero_block;
    test_known_path;
    test_backpressure;
    test_busy_ignored;
    test_reset_mid_trace;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
